// File: rtl/ysyx_23060208_idu_rx.sv
// IDU receive stage: 2-entry skid buffer on the IFU->IDU channel with
// combinational RV32I pre-decode of the head entry toward the EXU.
module ysyx_23060208_idu_rx #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*DATA_WIDTH-1:0] ifu_to_idu_data_i,
    input  logic                    ifu_to_idu_valid,
    output logic                    idu_to_ifu_ready,
    input  logic                    flush,
    output logic                    idu_to_exu_valid,
    input  logic                    exu_to_idu_ready,
    output logic [DATA_WIDTH-1:0]   idu_pc_o,
    output logic [DATA_WIDTH-1:0]   idu_inst_o,
    output logic [2:0]              idu_type_o,
    output logic [4:0]              idu_rd_o,
    output logic [4:0]              idu_rs1_o,
    output logic [4:0]              idu_rs2_o,
    output logic [DATA_WIDTH-1:0]   idu_imm_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        T_R       = 3'd0,
        T_I       = 3'd1,
        T_S       = 3'd2,
        T_B       = 3'd3,
        T_U       = 3'd4,
        T_J       = 3'd5,
        T_ILLEGAL = 3'd7
    } fmt_t;

    state_t                  state, state_next;
    logic                    head, tail;
    logic [2*DATA_WIDTH-1:0] mem [2];
    logic                    push, pop;
    logic [DATA_WIDTH-1:0]   inst, pc;
    fmt_t                    fmt;

    // Handshakes depend on state only, so ready has no path from the EXU side.
    assign idu_to_ifu_ready = (state != FULL);
    assign idu_to_exu_valid = (state != EMPTY);
    assign push             = ifu_to_idu_valid && idu_to_ifu_ready;
    assign pop              = idu_to_exu_valid && exu_to_idu_ready;

    // Occupancy state register; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) state <= EMPTY;
        else              state <= state_next;
    end

    // Next occupancy from push/pop.
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = FULL;
                else if (pop && !push) state_next = EMPTY;
            end
            FULL:  if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Head/tail pointers wrap modulo 2.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= 1'b0;
            tail <= 1'b0;
        end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
        end
    end

    // Entry storage: written only on an accepted, non-flushed push.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push && !flush) begin
            mem[tail] <= ifu_to_idu_data_i;
        end
    end

    // Pre-decode of the head entry; all fields forced to idle values when empty.
    always_comb begin
        pc         = mem[head][2*DATA_WIDTH-1:DATA_WIDTH];
        inst       = mem[head][DATA_WIDTH-1:0];
        fmt        = T_ILLEGAL;
        idu_imm_o  = '0;
        unique case (inst[6:0])
            7'b0110011: fmt = T_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                fmt       = T_I;
                idu_imm_o = DATA_WIDTH'($signed(inst[31:20]));
            end
            7'b0100011: begin
                fmt       = T_S;
                idu_imm_o = DATA_WIDTH'($signed({inst[31:25], inst[11:7]}));
            end
            7'b1100011: begin
                fmt       = T_B;
                idu_imm_o = DATA_WIDTH'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                fmt       = T_U;
                idu_imm_o = DATA_WIDTH'($signed({inst[31:12], 12'b0}));
            end
            7'b1101111: begin
                fmt       = T_J;
                idu_imm_o = DATA_WIDTH'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            end
            default: ;
        endcase
        idu_pc_o   = pc;
        idu_inst_o = inst;
        idu_type_o = fmt;
        idu_rd_o   = inst[11:7];
        idu_rs1_o  = inst[19:15];
        idu_rs2_o  = inst[24:20];
        if (state == EMPTY) begin
            idu_pc_o   = '0;
            idu_inst_o = '0;
            idu_type_o = T_ILLEGAL;
            idu_rd_o   = '0;
            idu_rs1_o  = '0;
            idu_rs2_o  = '0;
            idu_imm_o  = '0;
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_idu_rx.sv
// Bench for ysyx_23060208_idu_rx: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_ysyx_23060208_idu_rx;

    logic        clk = 1'b0;
    logic        rst, flush, ifu_valid, exu_ready;
    logic [63:0] ifu_data;
    logic        ifu_ready, exu_valid;
    logic [31:0] pc_o, inst_o, imm_o;
    logic [2:0]  type_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [63:0] mq[$];      // reference buffer contents, head at index 0
    logic [31:0] popped[$];  // pcs handed to the EXU
    bit          accepted;   // last edge took the IFU beat

    ysyx_23060208_idu_rx #(.DATA_WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .ifu_to_idu_data_i (ifu_data),
        .ifu_to_idu_valid  (ifu_valid),
        .idu_to_ifu_ready  (ifu_ready),
        .flush             (flush),
        .idu_to_exu_valid  (exu_valid),
        .exu_to_idu_ready  (exu_ready),
        .idu_pc_o          (pc_o),
        .idu_inst_o        (inst_o),
        .idu_type_o        (type_o),
        .idu_rd_o          (rd_o),
        .idu_rs1_o         (rs1_o),
        .idu_rs2_o         (rs2_o),
        .idu_imm_o         (imm_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference RV32I decode written directly from the format tables.
    task automatic ref_decode(input logic [31:0] i, output logic [2:0] t, output logic [31:0] imm);
        t = 3'd7; imm = 32'd0;
        case (i[6:0])
            7'h33: t = 3'd0;
            7'h13, 7'h03, 7'h67, 7'h73: begin t = 3'd1; imm = {{20{i[31]}}, i[31:20]}; end
            7'h23: begin t = 3'd2; imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
            7'h63: begin t = 3'd3; imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
            7'h37, 7'h17: begin t = 3'd4; imm = {i[31:12], 12'd0}; end
            7'h6F: begin t = 3'd5; imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
            default: ;
        endcase
    endtask

    // Compare every output with the model's head entry.
    task automatic check_all(input string tag);
        logic [31:0] i, ex_imm;
        logic [2:0]  ex_t;
        chk({tag, ".ready"}, 32'(ifu_ready), 32'(mq.size() < 2));
        chk({tag, ".valid"}, 32'(exu_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            i = mq[0][31:0];
            ref_decode(i, ex_t, ex_imm);
            chk({tag, ".pc"},   pc_o, mq[0][63:32]);
            chk({tag, ".inst"}, inst_o, i);
            chk({tag, ".type"}, 32'(type_o), 32'(ex_t));
            chk({tag, ".imm"},  imm_o, ex_imm);
            chk({tag, ".regs"}, {17'd0, rd_o, rs1_o, rs2_o}, {17'd0, i[11:7], i[19:15], i[24:20]});
        end else begin
            chk({tag, ".idle"}, pc_o | inst_o | imm_o | 32'({rd_o, rs1_o, rs2_o}), 32'd0);
            chk({tag, ".idle_type"}, 32'(type_o), 32'd7);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic cyc(input string tag, input bit v, input logic [63:0] d,
                       input bit r, input bit fl, input bit rs);
        bit rdy, vld;
        ifu_valid = v; ifu_data = d; exu_ready = r; flush = fl; rst = rs;
        @(posedge clk);
        rdy = mq.size() < 2;
        vld = mq.size() > 0;
        accepted = 1'b0;
        if (rs || fl) begin
            mq.delete();
        end else begin
            if (vld && r) popped.push_back(mq.pop_front() >> 32);
            if (v && rdy) begin mq.push_back(d); accepted = 1'b1; end
        end
        #1;
        check_all(tag);
    endtask

    function automatic logic [63:0] beat(input logic [31:0] p, input logic [31:0] i);
        return {p, i};
    endfunction

    logic [63:0] pend[$];
    logic [6:0]  ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};

    initial begin
        ifu_valid = 0; ifu_data = '0; exu_ready = 0; flush = 0; rst = 1;

        // reset state
        cyc("rst", 0, '0, 0, 0, 1);
        cyc("rst2", 0, '0, 0, 0, 1);

        // 1: single I-type beat, popped immediately
        cyc("t1.push", 1, beat(32'h80000000, 32'h00500093), 1, 0, 0);
        chk("t1.valid", 32'(exu_valid), 32'd1);
        chk("t1.type", 32'(type_o), 32'd1);
        chk("t1.rd", 32'(rd_o), 32'd1);
        chk("t1.rs1", 32'(rs1_o), 32'd0);
        chk("t1.imm", imm_o, 32'h5);
        cyc("t1.pop", 0, '0, 1, 0, 0);
        chk("t1.after", 32'(exu_valid), 32'd0);

        // 2: back-pressure with three offered beats
        popped.delete();
        for (int unsigned k = 0; k < 3; k++) pend.push_back(beat(32'h80000000 + 4 * k, 32'h00000013));
        for (int unsigned k = 0; k < 3; k++) begin
            cyc("t2.fill", 1, pend[0], 0, 0, 0);
            if (accepted) void'(pend.pop_front());
        end
        chk("t2.full_ready", 32'(ifu_ready), 32'd0);
        chk("t2.held", 32'(pend.size()), 32'd1);
        cyc("t2.pop1", 1, pend[0], 1, 0, 0);
        if (accepted) void'(pend.pop_front());
        chk("t2.ready_back", 32'(ifu_ready), 32'd1);
        for (int unsigned k = 0; k < 6 && (pend.size() > 0 || mq.size() > 0); k++) begin
            cyc("t2.drain", pend.size() > 0, pend.size() > 0 ? pend[0] : 64'd0, 1, 0, 0);
            if (accepted) void'(pend.pop_front());
        end
        chk("t2.npop", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            chk("t2.ord0", popped[0], 32'h80000000);
            chk("t2.ord1", popped[1], 32'h80000004);
            chk("t2.ord2", popped[2], 32'h80000008);
        end

        // 3: streaming in state ONE, push and pop together
        popped.delete();
        cyc("t3.prime", 1, beat(32'h1000, 32'h00100093), 0, 0, 0);
        for (int unsigned k = 1; k <= 10; k++) begin
            cyc("t3.stream", 1, beat(32'h1000 + 4 * k, 32'h00100093), 1, 0, 0);
            chk("t3.one", 32'(exu_valid && ifu_ready), 32'd1);
        end
        cyc("t3.last", 0, '0, 1, 0, 0);
        chk("t3.count", 32'(popped.size()), 32'd11);
        for (int unsigned k = 0; k < popped.size(); k++) chk("t3.order", popped[k], 32'h1000 + 4 * k);

        // 4: decode corners
        cyc("t4.b", 1, beat(32'h2000, 32'hFE000EE3), 0, 0, 0);
        chk("t4.btype", 32'(type_o), 32'd3);
        chk("t4.brs", 32'({rs1_o, rs2_o}), 32'd0);
        chk("t4.bimm", imm_o, 32'hFFFFFFFC);
        cyc("t4.u", 1, beat(32'h2004, 32'h123450B7), 1, 0, 0);
        chk("t4.utype", 32'(type_o), 32'd4);
        chk("t4.urd", 32'(rd_o), 32'd1);
        chk("t4.uimm", imm_o, 32'h12345000);
        cyc("t4.z", 1, beat(32'h2008, 32'h00000000), 1, 0, 0);
        chk("t4.ztype", 32'(type_o), 32'd7);
        chk("t4.zimm", imm_o, 32'd0);
        cyc("t4.drain", 0, '0, 1, 0, 0);

        // 5: flush while full and EXU ready
        popped.delete();
        cyc("t5.f1", 1, beat(32'h3000, 32'h00000013), 0, 0, 0);
        cyc("t5.f2", 1, beat(32'h3004, 32'h00000013), 0, 0, 0);
        cyc("t5.flush", 0, '0, 1, 1, 0);
        chk("t5.valid", 32'(exu_valid), 32'd0);
        chk("t5.ready", 32'(ifu_ready), 32'd1);
        chk("t5.nopop", 32'(popped.size()), 32'd0);
        cyc("t5.new", 1, beat(32'h4000, 32'h00000013), 0, 0, 0);
        chk("t5.first", pc_o, 32'h4000);
        cyc("t5.drain", 0, '0, 1, 0, 0);

        // 6: reset while full with a push offered
        cyc("t6.f1", 1, beat(32'h5000, 32'h00000013), 0, 0, 0);
        cyc("t6.f2", 1, beat(32'h5004, 32'h00000013), 0, 0, 0);
        cyc("t6.rst", 1, beat(32'h5008, 32'h00000013), 1, 1, 1);
        chk("t6.valid", 32'(exu_valid), 32'd0);
        chk("t6.ready", 32'(ifu_ready), 32'd1);
        chk("t6.type", 32'(type_o), 32'd7);
        cyc("t6.idle", 0, '0, 0, 0, 0);

        // Random traffic against the model
        for (int unsigned k = 0; k < 400; k++) begin
            logic [31:0] i;
            i = $urandom;
            i[6:0] = ops[$urandom_range(0, 9)];
            cyc("rnd", $urandom_range(0, 3) != 0, beat($urandom, i),
                $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
